matrix_stream_engine: RTL and testbench
=======================================

MATRIX_STREAM_ENGINE -- requirements
Module: matrix_stream_engine

Interface
REQ-001 Parameter MAX_N, default 4: largest supported square matrix dimension (2..8).
REQ-002 Parameter ACC_W, default 24: result element width; SHALL be a multiple of 8 and at least 16+clog2(MAX_N).
REQ-003 Parameter SIGNED, default 0: 0 means elements are unsigned bytes, 1 means two's-complement bytes.
REQ-004 clk  in  1  system clock; the only clock in the block.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 rx_data  in  8  received byte; valid only while rx_valid=1.
REQ-007 rx_valid  in  1  single-cycle strobe marking one new byte.
REQ-008 tx_busy  in  1  high while the UART transmitter is sending.
REQ-009 tx_data  out  8  byte to transmit; stable from tx_start until tx_busy falls.
REQ-010 tx_start  out  1  single-cycle transmit request.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 current_state  out  3  state encoding.
REQ-013 matrix_size  out  4  latched N; 0 when idle after reset.
REQ-014 err  out  1  single-cycle pulse when a header byte is illegal.

Function
REQ-015 The state machine SHALL have the states IDLE=0, LOAD_A=1, LOAD_B=2, COMPUTE=3 and SEND=4.
REQ-016 IDLE: the first rx_valid byte is the header N.
 - If 1<=N<=MAX_N: latch N into matrix_size and go to LOAD_A on the next cycle.
 - Otherwise: pulse err and remain in IDLE.
REQ-017 LOAD_A SHALL store N*N bytes row-major (A[0][0], A[0][1], ...), then go to LOAD_B; LOAD_B SHALL do the same for B, then go to COMPUTE.
REQ-018 In IDLE, LOAD_A and LOAD_B the block SHALL accept an rx_valid strobe on every cycle without loss.
REQ-019 rx_valid SHALL be ignored in COMPUTE and SEND; those bytes are dropped.
REQ-020 COMPUTE: one multiply-accumulate per cycle, C[i][j] = sum over k of A[i][k]*B[k][j], elements computed in row-major order.
 - Each element takes N cycles.
 - The accumulator SHALL clear at k=0.
 - The element SHALL be written to C storage in the cycle after k=N-1.
 - COMPUTE therefore lasts exactly N*N*(N+1) cycles.
REQ-021 Products SHALL be 16-bit values, sign-extended or zero-extended to ACC_W according to SIGNED; the accumulator SHALL wrap modulo 2^ACC_W.
REQ-022 SEND: transmit C row-major, each element as ACC_W/8 bytes, least-significant byte first.
REQ-023 tx_start SHALL pulse only when tx_busy=0. After each pulse the block SHALL wait for tx_busy to rise and then fall before issuing the next byte.
REQ-024 After the last byte completes (tx_busy falls), the block SHALL go to IDLE. matrix_size SHALL keep N until the next valid header.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While rst=0, all of the following SHALL hold, asynchronously:
 - state = IDLE;
 - tx_start, err, busy = 0;
 - tx_data and matrix_size = 0;
 - all counters and the accumulator = 0.
REQ-027 Asserting reset mid-operation SHALL abandon the transfer. Matrix storage need not be cleared.
REQ-028 The first rx_valid accepted after reset is released SHALL be treated as a header.

Structure
REQ-029 The state encodings, MAX_N range limits and the byte count per result (ACC_W/8) SHALL live in the shared matrix_pkg package.
REQ-030 The multiply-accumulate datapath SHALL be a sub-module named mac_unit, with parameters ACC_W and SIGNED and inputs clr, en, a and b.
REQ-031 A, B and C storage SHALL be MAX_N*MAX_N register arrays inside matrix_stream_engine.

Verification
REQ-032 SIGNED=0, input bytes 02,01,02,03,04,05,06,07,08 -> COMPUTE lasts 12 cycles, then TX bytes 13 00 00 16 00 00 2B 00 00 32 00 00, then IDLE.
REQ-033 Header 00, then header 05 (MAX_N=4) -> one err pulse for each, state stays 0, matrix_size stays 0.
REQ-034 SIGNED=0, N=4, all A and B bytes FF -> 16 results, each sent as 04 F8 03 (260100).
REQ-035 SIGNED=1, N=1, A=80, B=7F -> TX bytes 80 C0 FF (-16256).
REQ-036 tx_busy held high through SEND -> no tx_start is issued; releasing tx_busy yields exactly one tx_start.
REQ-037 Reset pulsed after 3 bytes of LOAD_B, then a new stream starts -> outputs return to reset values immediately, and the new stream completes correctly.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared encodings and sizing helpers for the matrix stream engine
package matrix_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_A  = 3'd1;
    localparam logic [2:0] ST_LOAD_B  = 3'd2;
    localparam logic [2:0] ST_COMPUTE = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;

    localparam int MAX_N_MIN = 2;
    localparam int MAX_N_MAX = 8;

    // Per-byte transmit handshake: request, wait for busy to rise, wait for it to fall
    typedef enum logic [1:0] {
        TX_ISSUE = 2'd0,
        TX_RISE  = 2'd1,
        TX_FALL  = 2'd2
    } tx_phase_e;

    function automatic int result_bytes(input int acc_w);
        return acc_w / 8;
    endfunction

endpackage

// File: rtl/matrix_stream_engine_if.sv
// rtl/matrix_stream_engine_if.sv - byte receive and UART transmit handshake bundle
interface matrix_stream_engine_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_busy,
        input  tx_data,
        input  tx_start
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_busy,
        output tx_data,
        output tx_start
    );

endinterface

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - byte multiply-accumulate with a wrapping ACC_W accumulator
module mac_unit #(
    parameter int ACC_W  = 24,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic [ACC_W-1:0] acc
);

    logic [15:0]      a_ext;
    logic [15:0]      b_ext;
    logic [15:0]      prod;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // The low 16 bits of a 16x16 product equal the signed 8x8 product once
    // both operands are sign-extended, so one multiplier covers both modes.
    assign a_ext    = SIGNED ? {{8{a[7]}}, a} : {8'h00, a};
    assign b_ext    = SIGNED ? {{8{b[7]}}, b} : {8'h00, b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = SIGNED ? {{(ACC_W-16){prod[15]}}, prod}
                             : {{(ACC_W-16){1'b0}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = clr ? prod_ext : acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matrix_stream_engine.sv
// rtl/matrix_stream_engine.sv - receives N, A and B over a byte stream, multiplies, streams C out
module matrix_stream_engine
    import matrix_pkg::*;
#(
    parameter int MAX_N  = 4,
    parameter int ACC_W  = 24,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_stream_engine_if.slave bus,
    output logic                 busy,
    output logic [2:0]           current_state,
    output logic [3:0]           matrix_size,
    output logic                 err
);

    localparam int         IW        = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int         KW        = $clog2(MAX_N + 1);
    localparam int         NB        = result_bytes(ACC_W);
    localparam logic [7:0] LAST_BYTE = 8'(NB - 1);
    localparam logic [7:0] MAX_HDR   = 8'(MAX_N);

    logic [2:0]       state_q, state_d;
    logic [3:0]       size_q, size_d;
    logic [IW-1:0]    row_q, row_d;
    logic [IW-1:0]    col_q, col_d;
    logic [KW-1:0]    k_q, k_d;
    logic [7:0]       byte_q, byte_d;
    tx_phase_e        phase_q, phase_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [7:0]       a_mem [MAX_N][MAX_N];
    logic [7:0]       b_mem [MAX_N][MAX_N];
    logic [ACC_W-1:0] c_mem [MAX_N][MAX_N];

    logic             a_we, b_we, c_we;
    logic [IW-1:0]    n_last;
    logic [KW-1:0]    k_end;
    logic [IW-1:0]    k_idx;
    logic             row_last, col_last, pos_last;
    logic [IW-1:0]    row_nx, col_nx;
    logic             hdr_ok;
    logic             mac_en, mac_clr;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] c_cur;

    assign n_last   = IW'(size_q - 4'd1);
    assign k_end    = KW'(size_q);
    assign k_idx    = k_q[IW-1:0];
    assign row_last = (row_q == n_last);
    assign col_last = (col_q == n_last);
    assign pos_last = row_last && col_last;
    assign hdr_ok   = (bus.rx_data != 8'd0) && (bus.rx_data <= MAX_HDR);
    assign c_cur    = c_mem[row_q][col_q];

    // Row-major walk over the active N x N region, shared by load, compute and send
    always_comb begin
        col_nx = col_last ? '0 : col_q + 1'b1;
        row_nx = row_q;
        if (col_last) begin
            row_nx = row_last ? '0 : row_q + 1'b1;
        end
    end

    // k runs 0..N-1 for the MACs; k == N is the write-back cycle for C[i][j]
    assign mac_en  = (state_q == ST_COMPUTE) && (k_q != k_end);
    assign mac_clr = (k_q == '0);

    mac_unit #(
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (a_mem[row_q][k_idx]),
        .b   (b_mem[k_idx][col_q]),
        .acc (acc)
    );

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        row_d      = row_q;
        col_d      = col_q;
        k_d        = k_q;
        byte_d     = byte_q;
        phase_d    = phase_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        err_d      = 1'b0;
        a_we       = 1'b0;
        b_we       = 1'b0;
        c_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (hdr_ok) begin
                        size_d  = bus.rx_data[3:0];
                        row_d   = '0;
                        col_d   = '0;
                        state_d = ST_LOAD_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_LOAD_A, ST_LOAD_B: begin
                if (bus.rx_valid) begin
                    a_we  = (state_q == ST_LOAD_A);
                    b_we  = (state_q == ST_LOAD_B);
                    row_d = row_nx;
                    col_d = col_nx;
                    if (pos_last) begin
                        k_d     = '0;
                        state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_COMPUTE;
                    end
                end
            end

            ST_COMPUTE: begin
                if (k_q == k_end) begin
                    c_we  = 1'b1;
                    k_d   = '0;
                    row_d = row_nx;
                    col_d = col_nx;
                    if (pos_last) begin
                        byte_d  = 8'd0;
                        phase_d = TX_ISSUE;
                        state_d = ST_SEND;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            ST_SEND: begin
                case (phase_q)
                    TX_ISSUE: begin
                        if (!bus.tx_busy) begin
                            tx_data_d  = 8'(c_cur >> {byte_q, 3'b000});
                            tx_start_d = 1'b1;
                            phase_d    = TX_RISE;
                        end
                    end
                    TX_RISE: begin
                        if (bus.tx_busy) begin
                            phase_d = TX_FALL;
                        end
                    end
                    TX_FALL: begin
                        if (!bus.tx_busy) begin
                            phase_d = TX_ISSUE;
                            if (byte_q == LAST_BYTE) begin
                                byte_d = 8'd0;
                                row_d  = row_nx;
                                col_d  = col_nx;
                                if (pos_last) begin
                                    state_d = ST_IDLE;
                                end
                            end else begin
                                byte_d = byte_q + 8'd1;
                            end
                        end
                    end
                    default: phase_d = TX_ISSUE;
                endcase
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            size_q     <= 4'd0;
            row_q      <= '0;
            col_q      <= '0;
            k_q        <= '0;
            byte_q     <= 8'd0;
            phase_q    <= TX_ISSUE;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            row_q      <= row_d;
            col_q      <= col_d;
            k_q        <= k_d;
            byte_q     <= byte_d;
            phase_q    <= phase_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Matrix storage is deliberately not reset; a new header always reloads it
    always_ff @(posedge clk) begin
        if (a_we) begin
            a_mem[row_q][col_q] <= bus.rx_data;
        end
        if (b_we) begin
            b_mem[row_q][col_q] <= bus.rx_data;
        end
        if (c_we) begin
            c_mem[row_q][col_q] <= acc;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign busy           = busy_q;
    assign current_state  = state_q;
    assign matrix_size    = size_q;
    assign err            = err_q;

endmodule

// File: tb/tb_matrix_stream_engine.sv
// tb/tb_matrix_stream_engine.sv - scoreboard bench for unsigned and signed engine instances
module tb_matrix_stream_engine;

    localparam int ACC_W = 24;
    localparam int NB    = ACC_W / 8;
    localparam int MAXN  = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       hold     = 1'b0;

    logic ub0 = 1'b0, ub1 = 1'b0, arm0 = 1'b0, arm1 = 1'b0;
    int   dly0 = 0, dur0 = 0, dly1 = 0, dur1 = 0;

    logic       busy0, busy1, err0, err1;
    logic [2:0] st0, st1;
    logic [3:0] sz0, sz1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] lit_q[$];
    logic [7:0] ma[MAXN*MAXN];
    logic [7:0] mb[MAXN*MAXN];

    int n_checks = 0;
    int n_err    = 0;
    int starts0  = 0;

    matrix_stream_engine_if bus0();
    matrix_stream_engine_if bus1();

    assign bus0.rx_data  = rx_data;
    assign bus0.rx_valid = rx_valid;
    assign bus0.tx_busy  = ub0 | hold;
    assign bus1.rx_data  = rx_data;
    assign bus1.rx_valid = rx_valid;
    assign bus1.tx_busy  = ub1 | hold;

    matrix_stream_engine #(.MAX_N(MAXN), .ACC_W(ACC_W), .SIGNED(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy0),
        .current_state(st0), .matrix_size(sz0), .err(err0)
    );

    matrix_stream_engine #(.MAX_N(MAXN), .ACC_W(ACC_W), .SIGNED(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1),
        .current_state(st1), .matrix_size(sz1), .err(err1)
    );

    always #5 clk = ~clk;

    // UART transmitter stand-ins: busy rises 1..3 cycles after a start and lasts 2..5 cycles
    always @(posedge clk) begin
        if (bus0.tx_start) begin
            dly0 <= $urandom_range(0, 2); dur0 <= $urandom_range(2, 5); arm0 <= 1'b1;
        end else if (arm0) begin
            if (dly0 > 0) dly0 <= dly0 - 1;
            else begin ub0 <= 1'b1; arm0 <= 1'b0; end
        end else if (ub0) begin
            if (dur0 > 1) dur0 <= dur0 - 1;
            else ub0 <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (bus1.tx_start) begin
            dly1 <= $urandom_range(0, 2); dur1 <= $urandom_range(2, 5); arm1 <= 1'b1;
        end else if (arm1) begin
            if (dly1 > 0) dly1 <= dly1 - 1;
            else begin ub1 <= 1'b1; arm1 <= 1'b0; end
        end else if (ub1) begin
            if (dur1 > 1) dur1 <= dur1 - 1;
            else ub1 <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus0.tx_start) begin
            starts0++;
            check("tx0_start_while_busy", bus0.tx_busy, 1'b0);
            if (q0.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL tx0_extra: got byte %02h, expected no byte", bus0.tx_data);
            end else begin
                check("tx0_byte", bus0.tx_data, q0.pop_front());
            end
        end
        if (rst && bus1.tx_start) begin
            check("tx1_start_while_busy", bus1.tx_busy, 1'b0);
            if (q1.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL tx1_extra: got byte %02h, expected no byte", bus1.tx_data);
            end else begin
                check("tx1_byte", bus1.tx_data, q1.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Reference: plain integer matrix product, reduced modulo 2^ACC_W, bytes LSB first
    task automatic push_expected(input int n, input int lit_lane);
        longint s, av, bv;
        logic [ACC_W-1:0] c;
        for (int lane = 0; lane < 2; lane++) begin
            if (lane == lit_lane) begin
                foreach (lit_q[x]) begin
                    if (lane == 0) q0.push_back(lit_q[x]); else q1.push_back(lit_q[x]);
                end
            end else begin
                for (int i = 0; i < n; i++) begin
                    for (int j = 0; j < n; j++) begin
                        s = 0;
                        for (int k = 0; k < n; k++) begin
                            av = longint'(ma[i*n+k]);
                            bv = longint'(mb[k*n+j]);
                            if (lane == 1 && av > 127) av = av - 256;
                            if (lane == 1 && bv > 127) bv = bv - 256;
                            s = s + av * bv;
                        end
                        c = ACC_W'(s);
                        for (int b = 0; b < NB; b++) begin
                            if (lane == 0) q0.push_back(c[8*b +: 8]); else q1.push_back(c[8*b +: 8]);
                        end
                    end
                end
            end
        end
        lit_q.delete();
    endtask

    task automatic feed(input int n, input int lit_lane);
        push_expected(n, lit_lane);
        send_byte(8'(n));
        check("hdr_state", st0, 3'd1);
        check("hdr_size", sz0, 4'(n));
        for (int i = 0; i < n*n; i++) begin
            if ($urandom_range(0, 2) == 0) tick();
            send_byte(ma[i]);
        end
        for (int i = 0; i < n*n; i++) begin
            if ($urandom_range(0, 2) == 0) tick();
            send_byte(mb[i]);
        end
    endtask

    task automatic wait_done(input int n, input bit chk_comp);
        int comp  = 0;
        int guard = 0;
        while ((st0 != 3'd0 || st1 != 3'd0) && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (st0 == 3'd3) comp++;
            if ((st0 == 3'd3 || st0 == 3'd4) && (st1 == 3'd3 || st1 == 3'd4) && $urandom_range(0, 3) == 0) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b0;
            end
        end
        rx_valid = 1'b0;
        check("done_in_time", guard < 20000, 1'b1);
        if (chk_comp) check("compute_cycles", comp, n*n*(n+1));
        check("size_kept0", sz0, 4'(n));
        check("size_kept1", sz1, 4'(n));
        check("busy_idle", busy0, 1'b0);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
    endtask

    task automatic bad_header(input logic [7:0] h, input logic [3:0] size_exp);
        send_byte(h);
        check("err0_pulse", err0, 1'b1);
        check("err1_pulse", err1, 1'b1);
        check("err_state", st0, 3'd0);
        tick();
        check("err_single", err0, 1'b0);
        check("err_size", sz0, size_exp);
    endtask

    task automatic random_matrices(input int n);
        for (int i = 0; i < n*n; i++) begin
            ma[i] = 8'($urandom);
            mb[i] = 8'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int g;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", st0, 3'd0);
        check("rst_busy", busy0, 1'b0);
        check("rst_size", sz0, 4'd0);
        check("rst_err", err0, 1'b0);
        check("rst_tx_start", bus0.tx_start, 1'b0);
        check("rst_tx_data", bus0.tx_data, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        tick();

        bad_header(8'h00, 4'd0);
        bad_header(8'h05, 4'd0);

        ma[0:3] = '{8'h01, 8'h02, 8'h03, 8'h04};
        mb[0:3] = '{8'h05, 8'h06, 8'h07, 8'h08};
        lit_q = '{8'h13, 8'h00, 8'h00, 8'h16, 8'h00, 8'h00,
                  8'h2B, 8'h00, 8'h00, 8'h32, 8'h00, 8'h00};
        feed(2, 0);
        wait_done(2, 1'b1);

        for (int i = 0; i < 16; i++) begin
            ma[i] = 8'hFF;
            mb[i] = 8'hFF;
            lit_q.push_back(8'h04);
            lit_q.push_back(8'hF8);
            lit_q.push_back(8'h03);
        end
        feed(4, 0);
        wait_done(4, 1'b1);

        ma[0] = 8'h80;
        mb[0] = 8'h7F;
        lit_q = '{8'h80, 8'hC0, 8'hFF};
        feed(1, 1);
        wait_done(1, 1'b1);

        bad_header(8'($urandom_range(5, 255)), 4'd1);

        hold = 1'b1;
        random_matrices(1);
        feed(1, -1);
        g = 0;
        while (st0 != 3'd4 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("send_reached", g < 500, 1'b1);
        s = starts0;
        repeat (20) @(negedge clk);
        check("no_start_while_held", starts0 - s, 0);
        check("held_busy", busy0, 1'b1);
        hold = 1'b0;
        repeat (3) @(negedge clk);
        check("one_start_on_release", starts0 - s, 1);
        wait_done(1, 1'b0);

        random_matrices(2);
        send_byte(8'd2);
        for (int i = 0; i < 4; i++) send_byte(ma[i]);
        for (int i = 0; i < 3; i++) send_byte(mb[i]);
        #2;
        rst = 1'b0;
        #1;
        check("arst_state", st0, 3'd0);
        check("arst_busy", busy0, 1'b0);
        check("arst_size", sz0, 4'd0);
        check("arst_err", err0, 1'b0);
        check("arst_tx_start", bus0.tx_start, 1'b0);
        check("arst_tx_data", bus0.tx_data, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, MAXN);
            random_matrices(n);
            feed(n, -1);
            wait_done(n, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
